// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default parameters
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_CE_DEF    = 27;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

endpackage

// File: rtl/uart_tick_gen.sv
// rtl/uart_tick_gen.sv - free-running oversample tick divider
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int UART_CE = UART_CE_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DW = $clog2(UART_CE + 1);

  logic [DW-1:0] div;

  // Count 0..UART_CE-1 and restart; the terminal count is the tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (div == DW'(UART_CE - 1)) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign tick = (div == DW'(UART_CE - 1));

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampled 8N1 UART receiver with valid/ready output
module uart_rx
  import uart_pkg::*;
#(
  parameter int UART_CE    = UART_CE_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE * (DATA_BITS + 2));
  localparam int BW = $clog2(DATA_BITS + 1);

  logic                 rxd_meta;
  logic                 rxd_s;
  logic                 tick;
  uart_state_t          state;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shift;
  logic                 stop_sample;
  logic                 commit;
  logic                 bad_stop;

  uart_tick_gen #(
    .UART_CE(UART_CE)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // Stop bit is judged mid-bit; the FSM leaves for IDLE on that same edge.
  assign stop_sample = (state == STOP) && tick && (tcnt == TW'(OVERSAMPLE - 1));
  assign commit      = stop_sample && rxd_s;
  assign bad_stop    = stop_sample && !rxd_s;
  assign busy        = (state != IDLE);

  // Framing FSM: start detect, mid-bit data sampling, stop check.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state <= START;
            tcnt  <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tcnt == TW'(OVERSAMPLE / 2 - 1)) begin
              tcnt <= '0;
              bcnt <= '0;
              state <= rxd_s ? IDLE : DATA;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tcnt == TW'(OVERSAMPLE - 1)) begin
              tcnt  <= '0;
              shift <= {rxd_s, shift[DATA_BITS-1:1]};
              if (bcnt == BW'(DATA_BITS - 1)) begin
                state <= STOP;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tcnt == TW'(OVERSAMPLE - 1)) begin
              tcnt  <= '0;
              state <= IDLE;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-entry output buffer; a transfer in the commit cycle frees the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= 1'b0;
      if (commit) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx #(
    .UART_CE   (1),
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    idle(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    rxd = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every transfer and tallies flag cycles.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h required none", rx_data);
        end else begin
          check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    idle(3);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b1;
    idle(20);

    // Single byte
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    idle(40);
    check("drain_55", exp_q.size(), 0);
    check("flags_55", fe_cnt + ov_cnt, 0);

    // Back-to-back frames
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(40);
    check("drain_a5_3c", exp_q.size(), 0);
    check("flags_a5_3c", fe_cnt + ov_cnt, 0);

    // False start
    rxd = 1'b0;
    idle(4);
    check("busy_false_start", int'(busy), 1);
    rxd = 1'b1;
    idle(12);
    check("busy_after_false_start", int'(busy), 0);
    idle(20);
    check("flags_false_start", fe_cnt + ov_cnt, 0);

    // Framing error then a good frame
    send_frame(8'h81, 1'b0);
    idle(40);
    check("frame_err_pulses", fe_cnt, 1);
    check("valid_after_frame_err", int'(rx_valid), 0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    idle(40);
    check("drain_42", exp_q.size(), 0);

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(30);
    check("overrun_pulses", ov_cnt, 1);
    check("held_valid", int'(rx_valid), 1);
    check("held_data", int'(rx_data), 8'h11);
    rx_ready = 1'b1;
    idle(1);
    check("valid_after_transfer", int'(rx_valid), 0);
    check("drain_11", exp_q.size(), 0);

    // Reset in the middle of a frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    idle(8);
    reset = 1'b0;
    #1;
    check("midreset_rx_data", int'(rx_data), 0);
    check("midreset_rx_valid", int'(rx_valid), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_flags", int'(frame_err) + int'(overrun), 0);
    idle(4);
    reset = 1'b1;
    idle(40);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    idle(40);
    check("drain_0f", exp_q.size(), 0);
    check("final_frame_err", fe_cnt, 1);
    check("final_overrun", ov_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
